match_resolver: RTL and testbench

MATCH_RESOLVER -- requirements
Module: match_resolver

---
 rtl/ap_pkg.sv | 13 +
 rtl/lsb_prio_enc.sv | 20 ++
 rtl/match_resolver.sv | 86 ++++++++
 tb/tb_match_resolver.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ap_pkg.sv
// rtl/ap_pkg.sv - shared FSM encoding and default geometry for the match resolver
package ap_pkg;

  localparam int AP_ROWS     = 16;
  localparam int AP_IDX_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } ap_state_t;

endpackage

// File: rtl/lsb_prio_enc.sv
// rtl/lsb_prio_enc.sv - combinational lowest-set-bit priority encoder
module lsb_prio_enc #(
  parameter int ROWS     = 16,
  parameter int IDX_BITS = 4
) (
  input  logic [ROWS-1:0]     vec,
  output logic [IDX_BITS-1:0] idx,
  output logic                any
);

  // Scan from the top down so the last hit written is the lowest set bit.
  always_comb begin
    idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_BITS'(i);
    end
    any = |vec;
  end

endmodule

// File: rtl/match_resolver.sv
// rtl/match_resolver.sv - captures CAM match lines and streams set row indices in ascending order
module match_resolver
  import ap_pkg::*;
#(
  parameter int ROWS     = AP_ROWS,
  parameter int IDX_BITS = AP_IDX_BITS
) (
  input  logic                clka,
  input  logic                rst,
  input  logic                start,
  input  logic [ROWS-1:0]     match_vec,
  output logic                busy,
  output logic                idx_valid,
  input  logic                idx_ready,
  output logic [IDX_BITS-1:0] idx,
  output logic                last,
  output logic [IDX_BITS:0]   match_count,
  output logic                done,
  output logic                none
);

  ap_state_t             state_q, state_d;
  logic [ROWS-1:0]       pending_q;
  logic [IDX_BITS:0]     count_q;
  logic [IDX_BITS:0]     pop;
  logic [IDX_BITS-1:0]   enc_idx;
  logic                  enc_any;
  logic                  one_left;

  lsb_prio_enc #(
    .ROWS     (ROWS),
    .IDX_BITS (IDX_BITS)
  ) u_enc (
    .vec (pending_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Population count of the live match lines; only consumed on the capture edge.
  always_comb begin
    pop = '0;
    for (int i = 0; i < ROWS; i++) begin
      pop = pop + (IDX_BITS+1)'(match_vec[i]);
    end
  end

  assign one_left = enc_any && ((pending_q & (pending_q - ROWS'(1))) == '0);

  always_ff @(posedge clka) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (pop != '0) ? ST_SCAN : ST_FIN;
      ST_SCAN: if (idx_ready && one_left) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      pending_q <= '0;
      count_q   <= '0;
    end else if (state_q == ST_IDLE && start) begin
      pending_q <= match_vec;
      count_q   <= pop;
    end else if (state_q == ST_SCAN && idx_ready) begin
      pending_q <= pending_q & ~(ROWS'(1) << enc_idx);
    end
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    idx_valid   = (state_q == ST_SCAN) && enc_any;
    idx         = (state_q == ST_SCAN) ? enc_idx : '0;
    last        = (state_q == ST_SCAN) && one_left;
    match_count = count_q;
    done        = (state_q == ST_FIN);
    none        = (state_q == ST_FIN) && (count_q == '0);
  end

endmodule

// File: tb/tb_match_resolver.sv
// tb/tb_match_resolver.sv - self-checking bench with queue-based reference model
module tb_match_resolver;

  localparam int ROWS     = 16;
  localparam int IDX_BITS = 4;

  logic                clka = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [ROWS-1:0]     match_vec = '0;
  logic                idx_ready = 1'b0;
  logic                busy, idx_valid, last, done, none;
  logic [IDX_BITS-1:0] idx;
  logic [IDX_BITS:0]   match_count;

  int errors = 0;
  int checks = 0;

  match_resolver #(.ROWS(ROWS), .IDX_BITS(IDX_BITS)) dut (
    .clka        (clka),
    .rst         (rst),
    .start       (start),
    .match_vec   (match_vec),
    .busy        (busy),
    .idx_valid   (idx_valid),
    .idx_ready   (idx_ready),
    .idx         (idx),
    .last        (last),
    .match_count (match_count),
    .done        (done),
    .none        (none)
  );

  always #5 clka = ~clka;

  // Reference model: remaining indices held as an ascending queue.
  localparam int M_IDLE = 0, M_SCAN = 1, M_FIN = 2;
  int m_mode = M_IDLE;
  int m_q[$];
  int m_cnt = 0;
  bit armed = 1'b0;

  always @(posedge clka) begin
    if (rst) begin
      m_mode = M_IDLE;
      m_q.delete();
      m_cnt = 0;
      armed = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin
          m_q.delete();
          for (int i = 0; i < ROWS; i++) if (match_vec[i]) m_q.push_back(i);
          m_cnt  = m_q.size();
          m_mode = (m_cnt != 0) ? M_SCAN : M_FIN;
        end
        M_SCAN: if (idx_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_mode = M_FIN;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clka) begin
    if (armed) begin
      chk("busy",        32'(busy),        32'(m_mode != M_IDLE));
      chk("idx_valid",   32'(idx_valid),   32'(m_mode == M_SCAN));
      chk("idx",         32'(idx),         (m_mode == M_SCAN) ? 32'(m_q[0]) : 32'd0);
      chk("last",        32'(last),        32'(m_mode == M_SCAN && m_q.size() == 1));
      chk("match_count", 32'(match_count), 32'(m_cnt));
      chk("done",        32'(done),        32'(m_mode == M_FIN));
      chk("none",        32'(none),        32'(m_mode == M_FIN && m_cnt == 0));
    end
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic do_start(input logic [ROWS-1:0] vec);
    start = 1'b1;
    match_vec = vec;
    tick();
    start = 1'b0;
    match_vec = 16'h5A3C;
  endtask

  int exp_seq[4] = '{0, 5, 10, 15};

  initial begin
    tick();
    tick();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_count", 32'(match_count), 0);
    rst = 1'b0;
    tick();

    // Zero matches: straight to FIN.
    idx_ready = 1'b1;
    do_start(16'h0000);
    chk("zero_done", 32'(done), 1);
    chk("zero_none", 32'(none), 1);
    chk("zero_valid", 32'(idx_valid), 0);
    chk("zero_count", 32'(match_count), 0);
    tick();
    chk("zero_done_pulse", 32'(done), 0);

    // Sparse vector at full throughput.
    do_start(16'h8421);
    for (int i = 0; i < 4; i++) begin
      chk("s8421_valid", 32'(idx_valid), 1);
      chk("s8421_idx", 32'(idx), 32'(exp_seq[i]));
      chk("s8421_last", 32'(last), 32'(i == 3));
      chk("s8421_count", 32'(match_count), 4);
      tick();
    end
    chk("s8421_done", 32'(done), 1);
    chk("s8421_none", 32'(none), 0);
    tick();

    // Back-to-back start in the IDLE cycle right after FIN, with backpressure.
    idx_ready = 1'b0;
    do_start(16'h0006);
    for (int i = 0; i < 3; i++) begin
      chk("s0006_hold_idx", 32'(idx), 1);
      chk("s0006_hold_last", 32'(last), 0);
      tick();
    end
    idx_ready = 1'b1;
    chk("s0006_idx1", 32'(idx), 1);
    tick();
    chk("s0006_idx2", 32'(idx), 2);
    chk("s0006_last2", 32'(last), 1);
    tick();
    chk("s0006_done", 32'(done), 1);
    tick();

    // All rows set.
    do_start(16'hFFFF);
    chk("sffff_count", 32'(match_count), 16);
    for (int i = 0; i < 16; i++) begin
      chk("sffff_idx", 32'(idx), 32'(i));
      tick();
    end
    chk("sffff_done", 32'(done), 1);
    tick();

    // Reset mid-SCAN after two of four indices.
    do_start(16'h00F0);
    tick();
    tick();
    chk("rst_mid_idx", 32'(idx), 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_valid", 32'(idx_valid), 0);
    chk("rst_mid_count", 32'(match_count), 0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_nodone", 32'(done), 0);
      tick();
    end

    // Start during SCAN is ignored.
    idx_ready = 1'b0;
    do_start(16'h0300);
    do_start(16'hFFFF);
    chk("ign_idx", 32'(idx), 8);
    chk("ign_count", 32'(match_count), 2);
    idx_ready = 1'b1;
    tick();
    chk("ign_idx9", 32'(idx), 9);
    chk("ign_last9", 32'(last), 1);
    tick();
    chk("ign_done", 32'(done), 1);
    tick();

    // Random vectors with random backpressure, checked by the model.
    for (int k = 0; k < 4; k++) begin
      int n;
      idx_ready = 1'b0;
      do_start(ROWS'($urandom));
      n = 0;
      while (!done && n < 200) begin
        idx_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      chk("rand_timeout", 32'(done), 1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
